// File: rtl/fetch_pkg.sv
// Shared types and helpers for the RV32IC fetch/align front end.
package fetch_pkg;

    localparam int unsigned HW_W = 16;
    localparam int unsigned XLEN = 32;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        WAIT = 2'd2,
        DROP = 2'd3
    } fetch_state_t;

    // One aligned instruction as presented to the decoder
    typedef struct packed {
        logic [XLEN-1:0] inst;
        logic [XLEN-1:0] pc;
        logic            compressed;
    } fetch_inst_t;

    // RVC encodings are every halfword whose two low bits are not 2'b11
    function automatic logic is_compressed(input logic [HW_W-1:0] hw);
        return (hw & HW_W'(3)) != HW_W'(3);
    endfunction

endpackage

// File: rtl/fetch_aligner_hw_fifo.sv
// Halfword circular buffer: pushes and pops 0, 1 or 2 halfwords per cycle.
module hw_fifo
    import fetch_pkg::*;
#(
    parameter int unsigned DEPTH = 4,
    localparam int unsigned CW   = $clog2(DEPTH) + 1
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            flush_i,
    input  logic [1:0]      push_cnt_i,
    input  logic [HW_W-1:0] push_hw0_i,
    input  logic [HW_W-1:0] push_hw1_i,
    input  logic [1:0]      pop_cnt_i,
    output logic [CW-1:0]   count_o,
    output logic [HW_W-1:0] hw0_c_o,
    output logic [HW_W-1:0] hw1_c_o
);

    localparam int unsigned PW = $clog2(DEPTH);

    logic [HW_W-1:0] mem_q [DEPTH];
    logic [PW-1:0]   rd_ptr_q, rd_ptr_d;
    logic [PW-1:0]   wr_ptr_q, wr_ptr_d;
    logic [CW-1:0]   count_q, count_d;

    // Pointer and occupancy update; flush empties the buffer
    always_comb begin
        rd_ptr_d = rd_ptr_q;
        wr_ptr_d = wr_ptr_q;
        count_d  = count_q;
        if (flush_i) begin
            rd_ptr_d = '0;
            wr_ptr_d = '0;
            count_d  = '0;
        end else begin
            rd_ptr_d = rd_ptr_q + PW'(pop_cnt_i);
            wr_ptr_d = wr_ptr_q + PW'(push_cnt_i);
            count_d  = count_q + CW'(push_cnt_i) - CW'(pop_cnt_i);
        end
    end

    // Pointer/count registers
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rd_ptr_q <= '0;
            wr_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            rd_ptr_q <= rd_ptr_d;
            wr_ptr_q <= wr_ptr_d;
            count_q  <= count_d;
        end
    end

    // Storage writes; lower halfword lands first
    always_ff @(posedge clk) begin
        if (!flush_i) begin
            if (push_cnt_i != 2'd0) begin
                mem_q[wr_ptr_q] <= push_hw0_i;
            end
            if (push_cnt_i == 2'd2) begin
                mem_q[wr_ptr_q + PW'(1)] <= push_hw1_i;
            end
        end
    end

    assign count_o = count_q;
    assign hw0_c_o = mem_q[rd_ptr_q];
    assign hw1_c_o = mem_q[rd_ptr_q + PW'(1)];

endmodule

// File: rtl/fetch_aligner.sv
// Fetch FSM, fetch/instruction PC tracking and redirect/stale-drop handling.
module fetch_aligner
    import fetch_pkg::*;
#(
    parameter logic [31:0] RESET_PC = 32'h0000_0000,
    parameter int unsigned HW_DEPTH = 4
) (
    input  logic        clk,
    input  logic        rst,
    output logic        imem_req_valid,
    input  logic        imem_req_ready,
    output logic [31:0] imem_req_addr,
    input  logic        imem_rsp_valid,
    input  logic [31:0] imem_rsp_data,
    input  logic        redirect_valid,
    input  logic [31:0] redirect_pc,
    output logic        inst_valid,
    input  logic        inst_ready,
    output logic [31:0] inst,
    output logic [31:0] inst_pc,
    output logic        c_inst_flag
);

    localparam int unsigned CW = $clog2(HW_DEPTH) + 1;

    fetch_state_t    state_q, state_d;
    logic [31:0]     fetch_pc_q, fetch_pc_d;
    logic [31:0]     inst_pc_q, inst_pc_d;
    logic [CW-1:0]   count;
    logic [HW_W-1:0] hw0, hw1;
    logic [HW_W-1:0] push_hw0, push_hw1;
    logic [1:0]      push_cnt, pop_cnt;
    logic            flush;
    logic            head_c;
    logic            can_req;
    fetch_inst_t     out_pkt;

    hw_fifo #(
        .DEPTH (HW_DEPTH)
    ) u_hw_fifo (
        .clk        (clk),
        .rst        (rst),
        .flush_i    (flush),
        .push_cnt_i (push_cnt),
        .push_hw0_i (push_hw0),
        .push_hw1_i (push_hw1),
        .pop_cnt_i  (pop_cnt),
        .count_o    (count),
        .hw0_c_o    (hw0),
        .hw1_c_o    (hw1)
    );

    // A request is only issued when a full word is guaranteed to fit
    assign can_req = (count <= CW'(HW_DEPTH - 2));

    // Next-state, buffer control and decoder-facing outputs
    always_comb begin
        state_d    = state_q;
        fetch_pc_d = fetch_pc_q;
        inst_pc_d  = inst_pc_q;
        push_cnt   = 2'd0;
        push_hw0   = imem_rsp_data[15:0];
        push_hw1   = imem_rsp_data[31:16];
        pop_cnt    = 2'd0;
        flush      = 1'b0;

        head_c         = is_compressed(hw0);
        inst_valid     = head_c ? (count >= CW'(1)) : (count >= CW'(2));
        imem_req_valid = (state_q == RUN) && can_req && !redirect_valid;
        imem_req_addr  = fetch_pc_q & 32'hFFFF_FFFC;

        out_pkt.inst       = '0;
        out_pkt.pc         = inst_pc_q;
        out_pkt.compressed = 1'b0;
        if (inst_valid) begin
            out_pkt.inst       = head_c ? {16'h0000, hw0} : {hw1, hw0};
            out_pkt.compressed = head_c;
        end

        if (inst_valid && inst_ready) begin
            pop_cnt   = head_c ? 2'd1 : 2'd2;
            inst_pc_d = inst_pc_q + (head_c ? 32'd2 : 32'd4);
        end

        case (state_q)
            IDLE: state_d = RUN;
            RUN: begin
                if (imem_req_valid && imem_req_ready) begin
                    state_d = WAIT;
                end
            end
            WAIT: begin
                if (imem_rsp_valid) begin
                    state_d = RUN;
                    // After an odd-halfword redirect the lower half precedes the target
                    if (fetch_pc_q[1]) begin
                        push_cnt = 2'd1;
                        push_hw0 = imem_rsp_data[31:16];
                    end else begin
                        push_cnt = 2'd2;
                    end
                    fetch_pc_d = (fetch_pc_q & 32'hFFFF_FFFC) + 32'd4;
                end
            end
            DROP: begin
                if (imem_rsp_valid) begin
                    state_d = RUN;
                end
            end
            default: state_d = IDLE;
        endcase

        // Redirect overrides push/pop; an in-flight response must then be dropped
        if (redirect_valid) begin
            flush      = 1'b1;
            push_cnt   = 2'd0;
            pop_cnt    = 2'd0;
            fetch_pc_d = redirect_pc & 32'hFFFF_FFFE;
            inst_pc_d  = redirect_pc & 32'hFFFF_FFFE;
            if ((state_q == WAIT || state_q == DROP) && !imem_rsp_valid) begin
                state_d = DROP;
            end else begin
                state_d = RUN;
            end
        end
    end

    assign inst        = out_pkt.inst;
    assign inst_pc     = out_pkt.pc;
    assign c_inst_flag = out_pkt.compressed;

    // State and PC registers
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q    <= IDLE;
            fetch_pc_q <= RESET_PC;
            inst_pc_q  <= RESET_PC;
        end else begin
            state_q    <= state_d;
            fetch_pc_q <= fetch_pc_d;
            inst_pc_q  <= inst_pc_d;
        end
    end

endmodule

// File: tb/tb_fetch_aligner.sv
// Directed bench for fetch_aligner: vector table plus hand-written redirect/back-pressure sequences.
module tb_fetch_aligner;

    logic        clk;
    logic        rst;
    logic        imem_req_valid;
    logic        imem_req_ready;
    logic [31:0] imem_req_addr;
    logic        imem_rsp_valid;
    logic [31:0] imem_rsp_data;
    logic        redirect_valid;
    logic [31:0] redirect_pc;
    logic        inst_valid;
    logic        inst_ready;
    logic [31:0] inst;
    logic [31:0] inst_pc;
    logic        c_inst_flag;

    logic [31:0] mem [64];
    int          rsp_lat;
    int          n_chk;
    int          n_fail;

    typedef struct {
        logic [31:0] inst;
        logic [31:0] pc;
        logic        c;
    } vec_t;

    vec_t vecs [16];

    fetch_aligner #(
        .RESET_PC (32'h0000_0000),
        .HW_DEPTH (4)
    ) dut (
        .clk            (clk),
        .rst            (rst),
        .imem_req_valid (imem_req_valid),
        .imem_req_ready (imem_req_ready),
        .imem_req_addr  (imem_req_addr),
        .imem_rsp_valid (imem_rsp_valid),
        .imem_rsp_data  (imem_rsp_data),
        .redirect_valid (redirect_valid),
        .redirect_pc    (redirect_pc),
        .inst_valid     (inst_valid),
        .inst_ready     (inst_ready),
        .inst           (inst),
        .inst_pc        (inst_pc),
        .c_inst_flag    (c_inst_flag)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // In-order memory, one outstanding request, response rsp_lat cycles after acceptance
    initial begin : mem_model
        logic        hs;
        logic [31:0] ha;
        logic        pend;
        logic [31:0] pa;
        int          pw;
        imem_rsp_valid = 1'b0;
        imem_rsp_data  = '0;
        pend = 1'b0;
        pa   = '0;
        pw   = 0;
        forever begin
            @(negedge clk);
            hs = imem_req_valid && imem_req_ready && !rst;
            ha = imem_req_addr;
            @(posedge clk);
            #1;
            imem_rsp_valid = 1'b0;
            if (rst) begin
                pend = 1'b0;
            end else begin
                if (hs) begin
                    pend = 1'b1;
                    pa   = ha;
                    pw   = rsp_lat - 1;
                end
                if (pend) begin
                    if (pw == 0) begin
                        imem_rsp_valid = 1'b1;
                        imem_rsp_data  = mem[pa[7:2]];
                        pend = 1'b0;
                    end else begin
                        pw = pw - 1;
                    end
                end
            end
        end
    end

    initial begin
        #400000;
        $display("FAIL watchdog: time limit reached, got no finish, required finish");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h, required 0x%08h", name, act, exp);
        end
    endtask

    task automatic do_reset();
        inst_ready     = 1'b0;
        redirect_valid = 1'b0;
        redirect_pc    = '0;
        rst            = 1'b1;
        repeat (3) @(posedge clk);
        #1 rst = 1'b0;
    endtask

    task automatic wait_inst(input string name);
        int k;
        k = 0;
        @(negedge clk);
        while (!inst_valid && k < 40) begin
            @(negedge clk);
            k++;
        end
        if (!inst_valid) begin
            n_chk++;
            n_fail++;
            $display("FAIL %s: inst_valid got 0 after 40 cycles, required 1", name);
        end
    endtask

    task automatic take();
        inst_ready = 1'b1;
        @(posedge clk);
        #1 inst_ready = 1'b0;
    endtask

    task automatic expect_vec(input int i);
        string nm;
        nm = $sformatf("vec%0d", i);
        wait_inst(nm);
        chk({nm, ".inst"}, inst, vecs[i].inst);
        chk({nm, ".pc"}, inst_pc, vecs[i].pc);
        chk({nm, ".c"}, 32'(c_inst_flag), 32'(vecs[i].c));
        take();
    endtask

    initial begin
        n_chk          = 0;
        n_fail         = 0;
        rst            = 1'b1;
        imem_req_ready = 1'b1;
        inst_ready     = 1'b0;
        redirect_valid = 1'b0;
        redirect_pc    = '0;
        rsp_lat        = 1;
        for (int i = 0; i < 64; i++) mem[i] = '0;

        vecs[0]  = '{32'h0000_4501, 32'h0000_0000, 1'b1};
        vecs[1]  = '{32'h00A0_0093, 32'h0000_0002, 1'b0};
        vecs[2]  = '{32'h0000_4585, 32'h0000_0006, 1'b1};
        vecs[3]  = '{32'h0000_4585, 32'h0000_0006, 1'b1};
        vecs[4]  = '{32'h0000_0001, 32'h0000_0008, 1'b1};
        vecs[5]  = '{32'h00A0_0093, 32'h0000_0000, 1'b0};
        vecs[6]  = '{32'h00B0_0113, 32'h0000_0004, 1'b0};
        vecs[7]  = '{32'h00C0_0193, 32'h0000_0008, 1'b0};
        vecs[8]  = '{32'h00D0_0213, 32'h0000_000C, 1'b0};
        vecs[9]  = '{32'h00E0_0293, 32'h0000_0010, 1'b0};
        vecs[10] = '{32'h00F0_0313, 32'h0000_0014, 1'b0};
        vecs[11] = '{32'h0000_4501, 32'h0000_0000, 1'b1};
        vecs[12] = '{32'h0000_4709, 32'h0000_0016, 1'b1};
        vecs[13] = '{32'h0000_4501, 32'hFFFF_FFFC, 1'b1};
        vecs[14] = '{32'h0000_4585, 32'hFFFF_FFFE, 1'b1};
        vecs[15] = '{32'h0000_4501, 32'h0000_0000, 1'b1};

        // Reset values, then first request
        mem[0] = 32'h00A0_0093;
        mem[1] = 32'h00B0_0113;
        repeat (2) @(negedge clk);
        chk("rst.req_valid", 32'(imem_req_valid), 32'd0);
        chk("rst.inst_valid", 32'(inst_valid), 32'd0);
        chk("rst.inst_pc", inst_pc, 32'h0);
        chk("rst.c_flag", 32'(c_inst_flag), 32'd0);
        @(posedge clk);
        #1 rst = 1'b0;
        @(negedge clk);
        chk("idle.req_valid", 32'(imem_req_valid), 32'd0);
        @(negedge clk);
        chk("run.req_valid", 32'(imem_req_valid), 32'd1);
        chk("run.req_addr", imem_req_addr, 32'h0);

        // Single 32-bit word; next request follows at +4
        wait_inst("t2");
        chk("t2.inst", inst, 32'h00A0_0093);
        chk("t2.c", 32'(c_inst_flag), 32'd0);
        chk("t2.pc", inst_pc, 32'h0);
        chk("t2.next_req_valid", 32'(imem_req_valid), 32'd1);
        chk("t2.next_req_addr", imem_req_addr, 32'h4);
        take();

        // Mixed compressed / straddling stream
        mem[0] = 32'h0093_4501;
        mem[1] = 32'h4585_00A0;
        mem[2] = 32'h0001_0001;
        do_reset();
        for (int i = 0; i <= 2; i++) expect_vec(i);

        // Redirect to 0x6 while the word-0 request is outstanding
        rsp_lat = 2;
        do_reset();
        @(posedge clk);
        #1;
        @(posedge clk);
        #1;
        redirect_valid = 1'b1;
        redirect_pc    = 32'h0000_0006;
        @(posedge clk);
        #1 redirect_valid = 1'b0;
        @(negedge clk);
        chk("t4.drop_req_valid", 32'(imem_req_valid), 32'd0);
        chk("t4.drop_inst_valid", 32'(inst_valid), 32'd0);
        chk("t4.drop_inst_pc", inst_pc, 32'h6);
        @(negedge clk);
        chk("t4.req_valid", 32'(imem_req_valid), 32'd1);
        chk("t4.req_addr", imem_req_addr, 32'h4);
        for (int i = 3; i <= 4; i++) expect_vec(i);

        // Back-pressure: buffer fills, requests stop, outputs hold
        rsp_lat = 1;
        mem[0] = 32'h00A0_0093;
        mem[1] = 32'h00B0_0113;
        mem[2] = 32'h00C0_0193;
        mem[3] = 32'h00D0_0213;
        mem[4] = 32'h00E0_0293;
        mem[5] = 32'h00F0_0313;
        do_reset();
        repeat (10) @(negedge clk);
        for (int k = 0; k < 3; k++) begin
            chk($sformatf("t5.full_req_valid%0d", k), 32'(imem_req_valid), 32'd0);
            chk($sformatf("t5.hold_inst%0d", k), inst, 32'h00A0_0093);
            chk($sformatf("t5.hold_valid%0d", k), 32'(inst_valid), 32'd1);
            @(negedge clk);
        end
        for (int i = 5; i <= 10; i++) expect_vec(i);

        // Redirect coincident with a response and an accepted instruction
        mem[0] = 32'h4501_4501;
        mem[1] = 32'h00A0_0093;
        mem[5] = 32'h4709_1234;
        do_reset();
        expect_vec(11);
        @(negedge clk);
        chk("t6.pre_inst_valid", 32'(inst_valid), 32'd1);
        chk("t6.pre_inst_pc", inst_pc, 32'h2);
        redirect_valid = 1'b1;
        redirect_pc    = 32'h0000_0017;
        inst_ready     = 1'b1;
        @(posedge clk);
        #1;
        redirect_valid = 1'b0;
        inst_ready     = 1'b0;
        @(negedge clk);
        chk("t6.inst_valid", 32'(inst_valid), 32'd0);
        chk("t6.inst_pc", inst_pc, 32'h16);
        chk("t6.req_valid", 32'(imem_req_valid), 32'd1);
        chk("t6.req_addr", imem_req_addr, 32'h14);
        expect_vec(12);

        // Redirect from IDLE to the top word; fetch PC wraps to zero
        mem[63] = 32'h4585_4501;
        do_reset();
        redirect_valid = 1'b1;
        redirect_pc    = 32'hFFFF_FFFC;
        @(posedge clk);
        #1 redirect_valid = 1'b0;
        @(negedge clk);
        chk("t7.req_valid", 32'(imem_req_valid), 32'd1);
        chk("t7.req_addr", imem_req_addr, 32'hFFFF_FFFC);
        wait_inst("t7.first");
        chk("t7.wrap_req_addr", imem_req_addr, 32'h0);
        chk("t7.wrap_req_valid", 32'(imem_req_valid), 32'd1);
        for (int i = 13; i <= 15; i++) expect_vec(i);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
